// File: rtl/panda_sc_data_bus_if.sv
// Single-outstanding load/store bridge between the core LSU and a req/gnt/rvalid data bus.
// A request is presented combinationally from the LSU in IDLE, then from captured registers until granted.
module panda_sc_data_bus_if #(
  parameter bit AlignAddr = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic [3:0]  lsu_we_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_stall_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2,
    DONE        = 2'd3
  } state_e;

  state_e      state_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  we_r;
  logic [31:0] rdata_r;
  logic        err_r;

  logic        req_s;
  logic        stall_s;
  logic [31:0] addr_sel_s;
  logic [31:0] wdata_sel_s;
  logic [3:0]  we_sel_s;

  // Select the bus request source: live LSU inputs in IDLE, captured copy while waiting for grant.
  always_comb begin
    req_s       = 1'b0;
    stall_s     = 1'b0;
    addr_sel_s  = 32'h0000_0000;
    wdata_sel_s = 32'h0000_0000;
    we_sel_s    = 4'b0000;
    case (state_r)
      IDLE: begin
        if (lsu_req_i && rst_ni) begin
          req_s       = 1'b1;
          stall_s     = 1'b1;
          addr_sel_s  = lsu_addr_i;
          wdata_sel_s = lsu_wdata_i;
          we_sel_s    = lsu_we_i;
        end else begin
          req_s   = 1'b0;
          stall_s = 1'b0;
        end
      end
      WAIT_GNT: begin
        req_s       = 1'b1;
        stall_s     = 1'b1;
        addr_sel_s  = addr_r;
        wdata_sel_s = wdata_r;
        we_sel_s    = we_r;
      end
      WAIT_RVALID: begin
        stall_s = 1'b1;
      end
      DONE: begin
        stall_s = 1'b0;
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase
  end

  assign data_req_o   = req_s;
  assign data_addr_o  = AlignAddr ? {addr_sel_s[31:2], 2'b00} : addr_sel_s;
  assign data_wdata_o = wdata_sel_s;
  assign data_we_o    = |we_sel_s;
  // A load asks for the whole word; a store uses its own strobes.
  assign data_be_o    = !req_s ? 4'b0000 : ((|we_sel_s) ? we_sel_s : 4'b1111);
  assign lsu_stall_o  = stall_s;
  assign lsu_rdata_o  = rdata_r;
  assign lsu_err_o    = (state_r == DONE) && err_r;

  // Transaction FSM with request capture and response capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      we_r    <= 4'b0000;
      rdata_r <= 32'h0000_0000;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (lsu_req_i) begin
            addr_r  <= lsu_addr_i;
            wdata_r <= lsu_wdata_i;
            we_r    <= lsu_we_i;
            state_r <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (data_gnt_i) begin
            state_r <= WAIT_RVALID;
          end
        end
        WAIT_RVALID: begin
          // Responses only count once the grant cycle is behind us.
          if (data_rvalid_i) begin
            rdata_r <= data_rdata_i;
            err_r   <= data_err_i;
            state_r <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/panda_sc_data_bus_if.md
PANDA_SC_DATA_BUS_IF -- requirements
Module: panda_sc_data_bus_if

Interface
- REQ-001: Parameter AlignAddr, default 1, meaning: 1 forces data_addr_o[1:0] to 2'b00, 0 passes the address unmodified.
- REQ-002: clk_i  input  1  single clock; all state updates on rising edge.
- REQ-003: rst_ni  input  1  asynchronous, active-low reset.
- REQ-004: lsu_req_i  input  1  core requests a load or store this instruction; held until lsu_stall_o=0.
- REQ-005: lsu_we_i  input  4  byte write strobes from the load/store unit (0000 = load).
- REQ-006: lsu_addr_i  input  32  access address.
- REQ-007: lsu_wdata_i  input  32  lane-replicated store data.
- REQ-008: lsu_rdata_o  output  32  load word returned to the load/store unit.
- REQ-009: lsu_stall_o  output  1  freezes the core while the access is outstanding.
- REQ-010: lsu_err_o  output  1  bus error flag for the completing access.
- REQ-011: data_req_o  output  1  bus request.
- REQ-012: data_gnt_i  input  1  bus grant.
- REQ-013: data_addr_o  output  32  bus address.
- REQ-014: data_we_o  output  1  bus write enable.
- REQ-015: data_be_o  output  4  bus byte enables.
- REQ-016: data_wdata_o  output  32  bus write data.
- REQ-017: data_rvalid_i  input  1  response valid, for loads and stores.
- REQ-018: data_rdata_i  input  32  response data.
- REQ-019: data_err_i  input  1  response error, qualified by data_rvalid_i.

Function
- REQ-020: The FSM SHALL have four states: IDLE, WAIT_GNT, WAIT_RVALID and DONE.
- REQ-021: IDLE, lsu_req_i=1: data_req_o=1, driven combinationally from lsu_* inputs; the request SHALL also be captured in registers.
  - If data_gnt_i=1, the next state SHALL be WAIT_RVALID.
  - Otherwise the next state SHALL be WAIT_GNT.
- REQ-022: WAIT_GNT:
  - data_req_o=1, driven from the captured registers, stable until grant.
  - On data_gnt_i=1 the next state SHALL be WAIT_RVALID.
- REQ-023: WAIT_RVALID:
  - data_req_o=0.
  - On data_rvalid_i=1: capture data_rdata_i and data_err_i, then go to DONE.
- REQ-024: DONE: lsu_stall_o=0, lsu_rdata_o=captured data, lsu_err_o=captured error; the next state SHALL be IDLE unconditionally.
- REQ-025: lsu_stall_o SHALL be combinationally 1 in these cases:
  - IDLE with lsu_req_i=1;
  - WAIT_GNT;
  - WAIT_RVALID.
- REQ-026: lsu_stall_o SHALL be 0 otherwise.
- REQ-027: Bus field mapping:
  - data_we_o = OR of strobes.
  - data_be_o = strobes for stores, 4'b1111 for loads.
  - data_wdata_o = store data.
  - data_addr_o per AlignAddr.
- REQ-028: Minimum access latency SHALL be 2 cycles from the request (grant in request cycle, rvalid next cycle, DONE next); each grant or rvalid wait cycle adds one.
- REQ-029: data_rvalid_i in IDLE, WAIT_GNT or DONE SHALL be ignored.
- REQ-030: data_rvalid_i asserted in the grant cycle SHALL be ignored; the response is taken from WAIT_RVALID only.
- REQ-031: data_err_i SHALL be ignored when data_rvalid_i=0.
- REQ-032: lsu_err_o SHALL be 1 only in DONE of an errored access; the core continues regardless.
- REQ-033: lsu_rdata_o SHALL hold its last captured value outside DONE.
- REQ-034: At most one transaction SHALL be outstanding.
- REQ-035: A new request SHALL be accepted only in IDLE.
- REQ-036: lsu_req_i seen in DONE SHALL NOT start a transaction; it is handled in the following IDLE cycle.

Reset
- REQ-037: rst_ni=0 SHALL asynchronously force IDLE, clear all captured registers, and drive these outputs to 0:
  - data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o;
  - lsu_rdata_o, lsu_err_o, lsu_stall_o.
- REQ-038: Reset mid-transaction SHALL abandon the access; a late data_rvalid_i after reset release SHALL be ignored per REQ-029.
- REQ-039: Deassertion is synchronised externally; the first request may be accepted on the first rising edge after release.

Verification
- REQ-040: Load, zero wait: addr 0x0000_1006, we 0000, gnt in request cycle, rvalid next with rdata 0xDEAD_BEEF, expect:
  - data_addr_o=0x0000_1004, data_be_o=1111, data_we_o=0;
  - stall for 2 cycles, then DONE with lsu_rdata_o=0xDEAD_BEEF.
- REQ-041: Store, grant delayed 3 cycles: we 0100, wdata 0x5A5A_5A5A, expect:
  - data_req_o high 4 cycles with address, be and wdata constant;
  - data_we_o=1, data_be_o=0100;
  - stall until the cycle after rvalid.
- REQ-042: Error response: rvalid with data_err_i=1 -> lsu_err_o=1 for exactly the DONE cycle, 0 afterwards.
- REQ-043: Spurious rvalid in IDLE and in the grant cycle -> no state change, no capture, lsu_rdata_o unchanged.
- REQ-044: Reset asserted in WAIT_RVALID, then rvalid after release -> IDLE, all outputs 0, late rvalid ignored, next request completes normally.
- REQ-045: Back-to-back requests (req held high across DONE) -> DONE then IDLE, second data_req_o two cycles after the first rvalid, no duplicate transaction.
